instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 30 +++
 rtl/instr_encoder.sv | 104 ++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Request/response bundle for the instruction encoder: the encoding request
// with its handshake, the memory-write side with its handshake, and status.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [12:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] addr;
  logic              full;
  logic              err;

  modport master (
    output clear, in_valid, op, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, instr, addr, full, err
  );

  modport slave (
    input  clear, in_valid, op, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, instr, addr, full, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes simple op/field requests into RV32I instruction words and presents
// them as sequential memory writes, one output register stage deep.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input logic           clk,
  input logic           rst,
  instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {FMT_I, FMT_S, FMT_R, FMT_B} fmt_t;

  logic              out_valid_reg;
  logic [31:0]       instr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              full_reg;
  logic              err_reg;

  logic              accept;
  logic              out_xfer;
  logic              legal;
  fmt_t              fmt;
  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [31:0]       enc;

  // The output slot may be refilled in the same cycle it drains.
  assign bus.in_ready  = !full_reg && (!out_valid_reg || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign out_xfer      = out_valid_reg && bus.out_ready;

  assign bus.out_valid = out_valid_reg;
  assign bus.instr     = instr_reg;
  assign bus.addr      = addr_reg;
  assign bus.full      = full_reg;
  assign bus.err       = err_reg;

  // Decode op into format, opcode and function fields.
  always_comb begin
    legal = 1'b1;
    fmt   = FMT_R;
    opc   = 7'b0110011;
    f3    = 3'b000;
    f7    = 7'b0000000;
    case (bus.op)
      4'd0:    begin fmt = FMT_I; opc = 7'b0000011; f3 = 3'b010; end
      4'd1:    begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b000; end
      4'd2:    begin fmt = FMT_S; opc = 7'b0100011; f3 = 3'b010; end
      4'd3:    f3 = 3'b000;
      4'd4:    begin f3 = 3'b000; f7 = 7'b0100000; end
      4'd5:    f3 = 3'b100;
      4'd6:    f3 = 3'b101;
      4'd7:    f3 = 3'b111;
      4'd8:    f3 = 3'b110;
      4'd9:    begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b000; end
      default: legal = 1'b0;
    endcase
  end

  // Assemble the instruction word; unused fields of each format never reach it.
  always_comb begin
    enc = '0;
    case (fmt)
      FMT_I: enc = {bus.imm[11:0], bus.rs1, f3, bus.rd, opc};
      FMT_S: enc = {bus.imm[11:5], bus.rs2, bus.rs1, f3, bus.imm[4:0], opc};
      FMT_B: enc = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, f3,
                    bus.imm[4:1], bus.imm[11], opc};
      default: enc = {f7, bus.rs2, bus.rs1, f3, bus.rd, opc};
    endcase
  end

  // Output slot, write address, full flag and illegal-op pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      instr_reg     <= '0;
      addr_reg      <= '0;
      full_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else if (bus.clear) begin
      // Restart drops any pending word and any request offered this cycle.
      out_valid_reg <= 1'b0;
      addr_reg      <= '0;
      full_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= accept && !legal;
      if (out_xfer) begin
        addr_reg <= addr_reg + 1'b1;
        if (addr_reg == '1) begin
          full_reg <= 1'b1;
        end
      end
      if (accept && legal) begin
        out_valid_reg <= 1'b1;
        instr_reg     <= enc;
      end else if (out_xfer) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule
